// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write signals of the program loader.
// The loader side (master) owns the memory write bus and the stream ready.
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 8
) ();
  logic [7:0]            byte_in;
  logic                  byte_valid;
  logic                  byte_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;

  modport master (
    input  byte_in, byte_valid,
    output byte_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output byte_in, byte_valid,
    input  byte_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Length-prefixed byte-stream loader that fills instruction memory and holds the core in reset.
// Optional illegal-opcode abort: define IMEM_LOADER_OPCODE_CHECK_EN.
module imem_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  imem_loader_if.master       bus,
  output logic                cpu_hold,
  output logic                done,
  output logic                error,
  output logic [ADDR_WIDTH:0] words_loaded
);
  typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, WRITE, DONE, ERROR} state_t;

  localparam logic [16:0] CAPACITY = 17'(1) << ADDR_WIDTH;

  state_t                state_reg, state_next;
  logic [15:0]           n_reg;
  logic [1:0]            byte_idx_reg;
  logic [23:0]           asm_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [31:0]           wdata_reg;
  logic [ADDR_WIDTH:0]   count_reg;
  logic [ADDR_WIDTH:0]   count_inc;
  logic [15:0]           len_full;
  logic                  xfer;
  logic                  word_ok;
  logic                  restart;

  assign xfer      = bus.byte_valid && bus.byte_ready;
  assign len_full  = {bus.byte_in, n_reg[7:0]};
  assign count_inc = count_reg + (ADDR_WIDTH+1)'(1);
  assign restart   = start && (state_reg == DONE || state_reg == ERROR);

`ifdef IMEM_LOADER_OPCODE_CHECK_EN
  // Only opcodes the control decoder understands may reach memory.
  assign word_ok = (wdata_reg[31:26] == 6'h00) || (wdata_reg[31:26] == 6'h08) ||
                   (wdata_reg[31:26] == 6'h0D);
`else
  assign word_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (start) state_next = LEN0;
      LEN0:  if (xfer) state_next = LEN1;
      LEN1: begin
        if (xfer) begin
          if (len_full == 16'd0)                  state_next = DONE;
          else if ({1'b0, len_full} > CAPACITY)   state_next = ERROR;
          else                                    state_next = DATA;
        end
      end
      DATA:  if (xfer && byte_idx_reg == 2'd3) state_next = WRITE;
      WRITE: begin
        if (!word_ok)                           state_next = ERROR;
        else if (17'(count_inc) == {1'b0, n_reg}) state_next = DONE;
        else                                    state_next = DATA;
      end
      DONE, ERROR: if (start) state_next = LEN0;
      default: state_next = IDLE;
    endcase
  end

  // Every status output is a pure decode of the state register.
  always_comb begin
    bus.byte_ready = 1'b0;
    bus.mem_we     = 1'b0;
    done           = 1'b0;
    error          = 1'b0;
    cpu_hold       = 1'b1;
    case (state_reg)
      LEN0, LEN1, DATA: bus.byte_ready = 1'b1;
      WRITE:            bus.mem_we = word_ok;
      DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
      end
      ERROR:            error = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      n_reg        <= '0;
      byte_idx_reg <= '0;
      asm_reg      <= '0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      count_reg    <= '0;
    end else begin
      if (state_reg == IDLE || restart) begin
        count_reg <= '0;
      end
      if (xfer) begin
        case (state_reg)
          LEN0: n_reg[7:0] <= bus.byte_in;
          LEN1: begin
            n_reg[15:8]  <= bus.byte_in;
            byte_idx_reg <= '0;
          end
          DATA: begin
            byte_idx_reg <= byte_idx_reg + 2'd1;
            case (byte_idx_reg)
              2'd0: asm_reg[7:0]   <= bus.byte_in;
              2'd1: asm_reg[15:8]  <= bus.byte_in;
              2'd2: asm_reg[23:16] <= bus.byte_in;
              default: begin
                // Publish the finished word only now so the bus holds steady between writes.
                wdata_reg <= {bus.byte_in, asm_reg};
                addr_reg  <= count_reg[ADDR_WIDTH-1:0];
              end
            endcase
          end
          default: ;
        endcase
      end
      if (state_reg == WRITE && word_ok) begin
        count_reg <= count_inc;
      end
    end
  end

  assign bus.mem_addr  = addr_reg;
  assign bus.mem_wdata = wdata_reg;
  assign words_loaded  = count_reg;
endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-stream program loader that is the writer side of the instruction memory. It receives a length-prefixed byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and writes them sequentially into instruction memory from word address 0. The MIPS core is held in reset through `cpu_hold` until a load completes.

## Interface
Parameters:
- `ADDR_WIDTH`, default 8: width of the word address. Capacity is 2^ADDR_WIDTH words.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request to begin a load. Honoured only in IDLE, DONE or ERROR.
- `byte_in`  in  8  stream data byte.
- `byte_valid`  in  1  `byte_in` is valid this cycle.
- `byte_ready`  out  1  loader accepts a byte this cycle.
- `mem_we`  out  1  instruction-memory write strobe, one cycle per word.
- `mem_addr`  out  ADDR_WIDTH  word address of the write.
- `mem_wdata`  out  32  assembled instruction word.
- `cpu_hold`  out  1  keeps the core in reset while high.
- `done`  out  1  load completed successfully.
- `error`  out  1  load aborted.
- `words_loaded`  out  ADDR_WIDTH+1  number of words written in the current or last load.

## Operation
- A byte transfers on any cycle with `byte_valid && byte_ready`. `byte_ready` is high only in LEN0, LEN1 and DATA.
- Stream format: N[7:0], N[15:8], then 4·N instruction bytes. Each word is sent LSB first: byte k goes to `mem_wdata[8k+7:8k]`.
- FSM states:
  - IDLE: `start` moves to LEN0. `words_loaded` clears.
  - LEN0: on transfer, latch N[7:0] and move to LEN1.
  - LEN1: on transfer, latch N[15:8]. Then:
    - N==0 goes to DONE.
    - N > 2^ADDR_WIDTH goes to ERROR.
    - Otherwise go to DATA with byte index 0 and word index 0.
  - DATA: on transfer, store the byte at the current index and increment the index (2 bits, wraps). On the 4th byte, move to WRITE.
  - WRITE: `mem_we`=1 for exactly one cycle, with `mem_addr` = word index and `mem_wdata` = assembled word. Then increment the word index and `words_loaded`. Go to DONE if the new count equals N, else back to DATA.
  - DONE: `done`=1. `start` begins a new load (to LEN0, clearing `words_loaded`, `done` drops).
  - ERROR: `error`=1. `start` begins a new load (to LEN0, `error` drops).
- `start` in LEN0, LEN1, DATA or WRITE is ignored.
- `cpu_hold` is 0 only in DONE; it is 1 in every other state.
- `mem_addr` and `mem_wdata` hold their last values outside WRITE. Memory samples them only when `mem_we`=1.

## Timing
- Reset values:
  - State IDLE; `byte_ready`, `mem_we`, `done`, `error` = 0.
  - `cpu_hold` = 1; `mem_addr`, `mem_wdata`, `words_loaded` = 0.
- All outputs are registered or decoded from state only. No combinational path from `byte_valid` to `byte_ready`.
- `start` sampled high in IDLE gives `byte_ready`=1 on the next cycle.
- Per-word cost with continuous valid: 4 transfer cycles + 1 WRITE cycle = 5 cycles.
- The cycle after the last WRITE has `done`=1 and `cpu_hold`=0.
- A full load of N words with no stalls takes 2 + 5N cycles after LEN0 entry.
- Deasserting `byte_valid` stalls the FSM in place with no state loss.
- An asynchronous reset mid-load returns to IDLE immediately:
  - `cpu_hold` goes back to 1, and any partial word is discarded.
  - `mem_we` drops in the same instant.
  - Already-written words are not erased.

## Configuration
- `IMEM_LOADER_OPCODE_CHECK_EN`, when defined:
  - In WRITE, if `mem_wdata[31:26]` is not one of the opcodes the control decoder supports (6'h00 R-type, 6'h08 ADDI, 6'h0D ORI), `mem_we` stays 0 and the FSM goes to ERROR.
  - `words_loaded` is not incremented, so it equals the index of the offending word.
- When undefined: every word is written regardless of opcode, and the illegal-opcode path does not exist.

## Test plan
- Reset → `cpu_hold`=1, `byte_ready`=0, `done`=0, `error`=0, `words_loaded`=0. Asserting `reset` low mid-DATA returns all of these within the same cycle.
- Pulse `start`, send 02 00, then 20 08 01 00 and 25 40 02 01 with continuous valid → two writes:
  - addr 0 = 32'h00010820 and addr 1 = 32'h01024025.
  - Each `mem_we` is one cycle wide; `done`=1 with `words_loaded`=2, and `cpu_hold` falls 12 cycles after LEN0 entry.
- Same stream with `byte_valid` toggling every other cycle → identical writes and data; only the timing stretches. No byte is lost or duplicated.
- Length 00 00 → DONE the cycle after LEN1, with no `mem_we`. Length 01 01 (257) with ADDR_WIDTH=8 → ERROR, no `mem_we`, `cpu_hold`=1. Then `start` reaches LEN0 and `error` clears.
- `start` pulsed during DATA is ignored and the load completes normally. `start` in DONE reloads 1 word (0x2008_0005 at addr 0) and `cpu_hold` reasserts during the load.
- With `IMEM_LOADER_OPCODE_CHECK_EN` defined, words 0x20080005 then 0x8C080000 (LW) → addr 0 written, second word not written, ERROR with `words_loaded`=1. Without the macro, both are written and the load reaches DONE.
